// File: rtl/otter_mmio_hub.sv
// rtl/otter_mmio_hub.sv - OTTER IOBUS peripheral hub: switches, LEDs, seven-segment, debounced buttons, IRQ.
module otter_mmio_hub #(
    parameter logic [31:0] BASE_AD = 32'h11000000,
    parameter int          SW_W    = 16,
    parameter int          LED_W   = 16,
    parameter int          NUM_BTN = 4,
    parameter int          DB_CYC  = 500000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [31:0]        IOBUS_ADDR,
    input  logic [31:0]        IOBUS_OUT,
    input  logic               IOBUS_WR,
    output logic [31:0]        IOBUS_IN,
    input  logic [SW_W-1:0]    SWITCHES,
    input  logic [NUM_BTN-1:0] BTN,
    output logic [LED_W-1:0]   LEDS,
    output logic [15:0]        SSEG,
    output logic               INTR
);
    localparam int          CW     = $clog2(DB_CYC);
    localparam logic [CW-1:0] C_MAX = CW'(DB_CYC - 1);

    localparam logic [31:0] A_SW   = BASE_AD;
    localparam logic [31:0] A_BTN  = BASE_AD + 32'h04;
    localparam logic [31:0] A_PEND = BASE_AD + 32'h08;
    localparam logic [31:0] A_IEN  = BASE_AD + 32'h0C;
    localparam logic [31:0] A_LEDS = BASE_AD + 32'h20;
    localparam logic [31:0] A_SSEG = BASE_AD + 32'h40;

    logic [SW_W-1:0]    r_sw_s1, r_sw_s2;
    logic [NUM_BTN-1:0] r_btn_s1, r_btn_s2;
    logic [NUM_BTN-1:0] r_db_s;
    logic [CW-1:0]      r_db_c [NUM_BTN];
    logic [NUM_BTN-1:0] r_pend, r_ien;
    logic [LED_W-1:0]   r_leds;
    logic [15:0]        r_sseg;
    logic               r_intr;

    logic [NUM_BTN-1:0] w_db_s_nx;
    logic [CW-1:0]      w_db_c_nx [NUM_BTN];
    logic [NUM_BTN-1:0] w_rise, w_clr;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_unused = ^IOBUS_OUT;

    // Counter restarts on any sample that matches the stable level, so only an
    // unbroken run of DB_CYC differing samples flips it.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            w_db_s_nx[i] = r_db_s[i];
            w_db_c_nx[i] = '0;
            if (r_btn_s2[i] != r_db_s[i]) begin
                if (r_db_c[i] == C_MAX) begin
                    w_db_s_nx[i] = ~r_db_s[i];
                end else begin
                    w_db_c_nx[i] = r_db_c[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise = w_db_s_nx & ~r_db_s;
    assign w_clr  = (IOBUS_WR && IOBUS_ADDR == A_PEND) ? IOBUS_OUT[NUM_BTN-1:0] : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_db_s   <= '0;
            for (int i = 0; i < NUM_BTN; i++) r_db_c[i] <= '0;
            r_pend   <= '0;
            r_ien    <= '0;
            r_leds   <= '0;
            r_sseg   <= '0;
            r_intr   <= 1'b0;
        end else begin
            r_sw_s1  <= SWITCHES;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= BTN;
            r_btn_s2 <= r_btn_s1;
            r_db_s   <= w_db_s_nx;
            for (int i = 0; i < NUM_BTN; i++) r_db_c[i] <= w_db_c_nx[i];
            // A fresh rising edge beats a same-cycle clear of that bit.
            r_pend   <= (r_pend & ~w_clr) | w_rise;
            r_intr   <= |(r_pend & r_ien);
            if (IOBUS_WR && IOBUS_ADDR == A_IEN)  r_ien  <= IOBUS_OUT[NUM_BTN-1:0];
            if (IOBUS_WR && IOBUS_ADDR == A_LEDS) r_leds <= IOBUS_OUT[LED_W-1:0];
            if (IOBUS_WR && IOBUS_ADDR == A_SSEG) r_sseg <= IOBUS_OUT[15:0];
        end
    end

    always_comb begin
        w_rdata = '0;
        case (IOBUS_ADDR)
            A_SW:    w_rdata[SW_W-1:0]    = r_sw_s2;
            A_BTN:   w_rdata[NUM_BTN-1:0] = r_db_s;
            A_PEND:  w_rdata[NUM_BTN-1:0] = r_pend;
            A_IEN:   w_rdata[NUM_BTN-1:0] = r_ien;
            A_LEDS:  w_rdata[LED_W-1:0]   = r_leds;
            A_SSEG:  w_rdata[15:0]        = r_sseg;
            default: w_rdata = '0;
        endcase
    end

    assign IOBUS_IN = w_rdata;
    assign LEDS     = r_leds;
    assign SSEG     = r_sseg;
    assign INTR     = r_intr;
endmodule

// File: tb/tb_otter_mmio_hub.sv
// tb/tb_otter_mmio_hub.sv - scoreboard bench for otter_mmio_hub against a cycle-level behavioural model.
module tb_otter_mmio_hub;
    localparam logic [31:0] BASE = 32'h11000000;
    localparam int SW_W = 16, LED_W = 16, NB = 4, DB = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic [31:0]       IOBUS_ADDR, IOBUS_OUT;
    logic              IOBUS_WR;
    logic [31:0]       IOBUS_IN;
    logic [SW_W-1:0]   SWITCHES;
    logic [NB-1:0]     BTN;
    logic [LED_W-1:0]  LEDS;
    logic [15:0]       SSEG;
    logic              INTR;

    otter_mmio_hub #(.BASE_AD(BASE), .SW_W(SW_W), .LED_W(LED_W), .NUM_BTN(NB), .DB_CYC(DB)) dut (
        .CLK(CLK), .RST(RST), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
        .IOBUS_IN(IOBUS_IN), .SWITCHES(SWITCHES), .BTN(BTN), .LEDS(LEDS), .SSEG(SSEG), .INTR(INTR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Behavioural model: raw input history, debounced levels, architectural registers.
    logic [31:0]     m_leds, m_sseg;
    logic [NB-1:0]   m_ien, m_pend, m_s;
    logic            m_intr;
    logic [SW_W-1:0] swq[$];
    logic [NB-1:0]   rq[$];
    logic [NB-1:0]   dq[$];
    bit              m_valid = 0;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a)
            BASE:         return 32'(swq[$-1]);
            BASE + 32'h4: return 32'(m_s);
            BASE + 32'h8: return 32'(m_pend);
            BASE + 32'hC: return 32'(m_ien);
            BASE + 32'h20: return m_leds;
            BASE + 32'h40: return m_sseg;
            default:      return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic [NB-1:0] d, ns, rise, clr;
        bit all_diff;
        if (RST) begin
            m_leds = 0; m_sseg = 0; m_ien = 0; m_pend = 0; m_s = 0; m_intr = 0;
            swq = '{0, 0};
            rq  = '{0, 0};
            dq  = {};
            m_valid = 1;
        end else begin
            d = rq[$-1];
            rq.push_back(BTN);       void'(rq.pop_front());
            swq.push_back(SWITCHES); void'(swq.pop_front());
            dq.push_back(d);
            if (dq.size() > DB) void'(dq.pop_front());
            ns = m_s;
            for (int b = 0; b < NB; b++) begin
                if (dq.size() == DB) begin
                    all_diff = 1;
                    for (int j = 0; j < DB; j++) if (dq[j][b] == m_s[b]) all_diff = 0;
                    if (all_diff) ns[b] = ~m_s[b];
                end
            end
            rise = ns & ~m_s;
            clr  = (IOBUS_WR && IOBUS_ADDR == BASE + 32'h8) ? IOBUS_OUT[NB-1:0] : '0;
            m_intr = |(m_pend & m_ien);
            m_pend = (m_pend & ~clr) | rise;
            m_s    = ns;
            if (IOBUS_WR && IOBUS_ADDR == BASE + 32'hC)  m_ien  = IOBUS_OUT[NB-1:0];
            if (IOBUS_WR && IOBUS_ADDR == BASE + 32'h20) m_leds = {16'h0, IOBUS_OUT[15:0]};
            if (IOBUS_WR && IOBUS_ADDR == BASE + 32'h40) m_sseg = {16'h0, IOBUS_OUT[15:0]};
        end
    endtask

    task automatic step(input logic rst, input logic wr, input logic [31:0] a, input logic [31:0] d);
        RST = rst; IOBUS_WR = wr; IOBUS_ADDR = a; IOBUS_OUT = d;
        if (m_valid) begin
            sbq.push_back('{0, a, m_read(a)});
            sbq.push_back('{1, a, m_leds});
            sbq.push_back('{2, a, m_sseg});
            sbq.push_back('{3, a, 32'(m_intr)});
        end
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [31:0] off, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, BASE + off, 32'h0);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        step(1'b0, 1'b1, BASE + off, d);
    endtask

    sb_t   e;
    logic [31:0] act;
    string nm;
    always @(negedge CLK) begin
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.kind)
                0: begin act = IOBUS_IN;     nm = "iobus_in"; end
                1: begin act = 32'(LEDS);    nm = "leds"; end
                2: begin act = 32'(SSEG);    nm = "sseg"; end
                default: begin act = 32'(INTR); nm = "intr"; end
            endcase
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s addr=%h actual=%h required=%h t=%0t", nm, e.addr, act, e.exp, $time);
            end
        end
    end

    logic [31:0] offs [9] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h20, 32'h40, 32'h44, 32'h10, 32'h24};

    initial begin
        SWITCHES = '0; BTN = '0;
        step(1'b1, 1'b1, BASE + 32'h20, 32'hFFFF);
        step(1'b1, 1'b1, BASE + 32'h20, 32'hFFFF);
        rd(32'h8, 2);

        wr(32'h40, 32'h1234);
        wr(32'h20, 32'hBEEF);
        rd(32'h40, 1); rd(32'h20, 1);
        wr(32'h44, 32'h5555);
        rd(32'h44, 1); rd(32'h40, 1);

        SWITCHES = 16'hA5A5;
        rd(32'h0, 4); rd(32'h10, 1);

        BTN[1] = 1'b1; rd(32'h4, 3); BTN[1] = 1'b0; rd(32'h8, 6);
        BTN[1] = 1'b1; rd(32'h4, 8); rd(32'h8, 1);
        BTN[1] = 1'b0; rd(32'h4, 8); rd(32'h8, 1);

        wr(32'hC, 32'h2); rd(32'h8, 3);
        wr(32'h8, 32'h2); rd(32'h8, 3);
        wr(32'hC, 32'h0);
        BTN[1] = 1'b1; rd(32'h8, 8);
        BTN[1] = 1'b0; rd(32'h4, 8);

        BTN[0] = 1'b1; rd(32'h8, 8); BTN[0] = 1'b0; rd(32'h8, 8);
        BTN[1] = 1'b1; rd(32'h8, 5);
        wr(32'h8, 32'h3);
        rd(32'h8, 3);
        BTN[1] = 1'b0; rd(32'h8, 8);

        BTN[2] = 1'b1;
        step(1'b1, 1'b0, BASE, 32'h0);
        rd(32'h8, 9);

        for (int c = 0; c < 600; c++) begin
            logic [31:0] a;
            if ($urandom_range(0, 4) == 0) BTN[$urandom_range(0, NB-1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) SWITCHES = SW_W'($urandom);
            a = ($urandom_range(0, 9) == 0) ? $urandom : BASE + offs[$urandom_range(0, 8)];
            if ($urandom_range(0, 7) == 0) a = BASE + 32'h8;
            step($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1, a,
                 ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15)));
        end

        rd(32'h0, 2);
        @(negedge CLK); #1;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain actual=%0d required=0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
